// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module   : alu_reservation_station
// Purpose  : 16-entry integer ALU reservation station with dual-CDB wakeup and
//            lowest-index-first registered issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ROB_RANGE
`define ROB_RANGE 4:0
`endif

module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int OP_W    = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              dispatch_valid,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic [31:0]       dispatch_Vj,
    input  logic [31:0]       dispatch_Vk,
    input  logic [`ROB_RANGE] dispatch_Qj,
    input  logic [`ROB_RANGE] dispatch_Qk,
    input  logic [`ROB_RANGE] dispatch_rob_id,
    input  logic [31:0]       cdb_alu_value,
    input  logic [`ROB_RANGE] cdb_alu_rob_id,
    input  logic [31:0]       cdb_mem_value,
    input  logic [`ROB_RANGE] cdb_mem_rob_id,
    output logic              full_out,
    output logic              alu_valid_out,
    output logic [OP_W-1:0]   alu_op_out,
    output logic [31:0]       alu_a_out,
    output logic [31:0]       alu_b_out,
    output logic [`ROB_RANGE] alu_rob_id_out
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q  [RS_SIZE];
    logic [OP_W-1:0]    op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [`ROB_RANGE]  qj_q  [RS_SIZE];
    logic [`ROB_RANGE]  qj_d  [RS_SIZE];
    logic [`ROB_RANGE]  qk_q  [RS_SIZE];
    logic [`ROB_RANGE]  qk_d  [RS_SIZE];
    logic [`ROB_RANGE]  rob_q [RS_SIZE];
    logic [`ROB_RANGE]  rob_d [RS_SIZE];

    logic               valid_q,   valid_d;
    logic [OP_W-1:0]    out_op_q,  out_op_d;
    logic [31:0]        out_a_q,   out_a_d;
    logic [31:0]        out_b_q,   out_b_d;
    logic [`ROB_RANGE]  out_rob_q, out_rob_d;

    logic [CNT_W-1:0]   free_cnt;
    logic [IDX_W-1:0]   alloc_idx, iss_idx;
    logic               alloc_ok,  iss_ok;
    logic [31:0]        disp_vj,   disp_vk;
    logic [`ROB_RANGE]  disp_qj,   disp_qk;

    // Descending scan leaves the lowest matching index in alloc_idx / iss_idx.
    always_comb begin
        free_cnt  = '0;
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        iss_ok    = 1'b0;
        iss_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_cnt  = free_cnt + CNT_W'(1);
                alloc_ok  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
                iss_ok  = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign full_out = (free_cnt == '0) || ((free_cnt == CNT_W'(1)) && dispatch_valid);

    // Operands arriving on a CDB in the dispatch cycle are captured directly.
    always_comb begin
        disp_vj = dispatch_Vj;
        disp_qj = dispatch_Qj;
        disp_vk = dispatch_Vk;
        disp_qk = dispatch_Qk;
        if (dispatch_Qj != '0 && dispatch_Qj == cdb_alu_rob_id) begin
            disp_vj = cdb_alu_value;
            disp_qj = '0;
        end else if (dispatch_Qj != '0 && dispatch_Qj == cdb_mem_rob_id) begin
            disp_vj = cdb_mem_value;
            disp_qj = '0;
        end
        if (dispatch_Qk != '0 && dispatch_Qk == cdb_alu_rob_id) begin
            disp_vk = cdb_alu_value;
            disp_qk = '0;
        end else if (dispatch_Qk != '0 && dispatch_Qk == cdb_mem_rob_id) begin
            disp_vk = cdb_mem_value;
            disp_qk = '0;
        end
    end

    always_comb begin
        busy_d    = busy_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        rob_d     = rob_q;
        valid_d   = 1'b0;
        out_op_d  = out_op_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_rob_d = out_rob_q;

        // A nonzero Q can only match a nonzero tag, so idle buses never wake.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                if (qj_q[i] != '0 && qj_q[i] == cdb_alu_rob_id) begin
                    vj_d[i] = cdb_alu_value;
                    qj_d[i] = '0;
                end else if (qj_q[i] != '0 && qj_q[i] == cdb_mem_rob_id) begin
                    vj_d[i] = cdb_mem_value;
                    qj_d[i] = '0;
                end
                if (qk_q[i] != '0 && qk_q[i] == cdb_alu_rob_id) begin
                    vk_d[i] = cdb_alu_value;
                    qk_d[i] = '0;
                end else if (qk_q[i] != '0 && qk_q[i] == cdb_mem_rob_id) begin
                    vk_d[i] = cdb_mem_value;
                    qk_d[i] = '0;
                end
            end
        end

        if (iss_ok) begin
            valid_d         = 1'b1;
            out_op_d        = op_q[iss_idx];
            out_a_d         = vj_q[iss_idx];
            out_b_d         = vk_q[iss_idx];
            out_rob_d       = rob_q[iss_idx];
            busy_d[iss_idx] = 1'b0;
        end

        // alloc_idx is never busy, so it cannot collide with the issued slot.
        if (dispatch_valid && alloc_ok) begin
            busy_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]   = dispatch_op;
            vj_d[alloc_idx]   = disp_vj;
            vk_d[alloc_idx]   = disp_vk;
            qj_d[alloc_idx]   = disp_qj;
            qk_d[alloc_idx]   = disp_qk;
            rob_d[alloc_idx]  = dispatch_rob_id;
        end

        if (flush_in) begin
            busy_d    = '0;
            valid_d   = 1'b0;
            out_op_d  = out_op_q;
            out_a_d   = out_a_q;
            out_b_d   = out_b_q;
            out_rob_d = out_rob_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            valid_q   <= 1'b0;
            out_op_q  <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_rob_q <= '0;
        end else if (rdy_in) begin
            busy_q    <= busy_d;
            op_q      <= op_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            rob_q     <= rob_d;
            valid_q   <= valid_d;
            out_op_q  <= out_op_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            out_rob_q <= out_rob_d;
        end
    end

    assign alu_valid_out  = valid_q;
    assign alu_op_out     = out_op_q;
    assign alu_a_out      = out_a_q;
    assign alu_b_out      = out_b_q;
    assign alu_rob_id_out = out_rob_q;

endmodule

`default_nettype wire
